// File: rtl/uart_pkg.sv
// Shared constants, FSM state types and parity helper for uart_bus_port.
// The parity states exist only when UART_PARITY_EN is defined.
package uart_pkg;

   localparam int CTRL_RX_INT_EN  = 31;
   localparam int CTRL_TX_INT_EN  = 30;
   localparam int CTRL_PARITY_EN  = 29;
   localparam int CTRL_PARITY_ODD = 28;
   localparam int CTRL_OVERRUN    = 27;
   localparam int CTRL_FRAME_ERR  = 26;
   localparam int CTRL_PARITY_ERR = 25;

   localparam int OVERSAMPLE = 16;
   localparam int MID_SAMPLE = 8;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      TX_PARITY = 3'd3,
`endif
      TX_STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
`ifdef UART_PARITY_EN
      RX_PARITY = 3'd3,
`endif
      RX_STOP   = 3'd4
   } rx_state_t;

   // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy level; pushes into a full FIFO are
// accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
   parameter int DEPTH_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [7:0]            din,
   output logic [7:0]            dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_BITS:0]   level
);
   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] LEVEL_FULL = (DEPTH_BITS + 1)'(DEPTH);

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (level == {(DEPTH_BITS + 1){1'b0}});
   assign full    = (level == LEVEL_FULL);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // pointers and level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= {DEPTH_BITS{1'b0}};
         rd_ptr <= {DEPTH_BITS{1'b0}};
         level  <= {(DEPTH_BITS + 1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + {{(DEPTH_BITS - 1){1'b0}}, 1'b1};
         if (do_pop)  rd_ptr <= rd_ptr + {{(DEPTH_BITS - 1){1'b0}}, 1'b1};
         case ({do_push, do_pop})
            2'b10:   level <= level + {{DEPTH_BITS{1'b0}}, 1'b1};
            2'b01:   level <= level - {{DEPTH_BITS{1'b0}}, 1'b1};
            default: level <= level;
         endcase
      end
   end

   // storage
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_bus_port.sv
// Single-clock bus UART: register file, baud tick generators, TX and RX FSMs.
// Optional feature macro: UART_PARITY_EN (parity generation/checking).
module uart_bus_port
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH_BITS = 4,
   parameter int PRESCALE        = 54
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] din,
   input  logic [3:0]  we,
   input  logic        en,
   input  logic        sel,
   output logic [7:0]  datRegOut,
   output logic [31:0] ctrlRegOut,
   output logic        interrupt,
   input  logic        uartRx,
   output logic        uartTx
);
   localparam int LW = FIFO_DEPTH_BITS + 1;

   logic        rx_int_en, tx_int_en, parity_en, parity_odd;
   logic        overrun, frame_err, parity_err;
   logic [7:0]  baud_div;
   logic [23:0] period_m1;
   logic        data_wr, data_rd, ctrl_wr, ctrl_hi_wr;

   logic          tx_push, tx_pop, tx_full, tx_empty;
   logic [7:0]    tx_head;
   logic [LW-1:0] tx_level;
   logic          rx_push, rx_full, rx_empty;
   logic [7:0]    rx_head;
   logic [LW-1:0] rx_level;

   tx_state_t   tx_state, tx_next;
   logic [23:0] tx_div;
   logic [3:0]  tx_os;
   logic [2:0]  tx_bit, tx_bit_nxt;
   logic [7:0]  tx_data;
   logic        tx_tick, tx_bit_end, tx_line;

   rx_state_t   rx_state, rx_next;
   logic [23:0] rx_div;
   logic [3:0]  rx_os;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic        rx_meta, rx_sync, rx_prev;
   logic        rx_tick, rx_sample, rx_restart;
   logic        set_overrun, set_frame_err;

   assign data_wr    = en & ~sel & we[0];
   assign data_rd    = en & ~sel & (we == 4'b0000);
   assign ctrl_wr    = en & sel;
   assign ctrl_hi_wr = ctrl_wr & we[3];
   assign period_m1  = (24'(baud_div) + 24'd1) * 24'(PRESCALE) - 24'd1;
   assign tx_push    = data_wr & (~tx_full | tx_pop);

   uart_sync_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS)) u_tx_fifo (
      .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(din[7:0]),
      .dout(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level)
   );

   uart_sync_fifo #(.DEPTH_BITS(FIFO_DEPTH_BITS)) u_rx_fifo (
      .clk(clk), .rst(rst), .push(rx_push), .pop(data_rd), .din(rx_shift),
      .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
   );

   assign datRegOut  = rx_empty ? 8'd0 : rx_head;
   assign ctrlRegOut = {rx_int_en, tx_int_en, parity_en, parity_odd, overrun, frame_err,
                        parity_err, 1'b0, baud_div, 8'(tx_level), 8'(rx_level)};

   // control fields and sticky flags; a set in the same cycle beats a clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_int_en <= 1'b1;
         tx_int_en <= 1'b0;
         baud_div  <= 8'd1;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (ctrl_hi_wr) begin
            rx_int_en <= din[CTRL_RX_INT_EN];
            tx_int_en <= din[CTRL_TX_INT_EN];
         end
         if (ctrl_wr & we[2]) baud_div <= din[23:16];
         overrun   <= (overrun & ~(ctrl_hi_wr & din[CTRL_OVERRUN])) | set_overrun;
         frame_err <= (frame_err & ~(ctrl_hi_wr & din[CTRL_FRAME_ERR])) | set_frame_err;
      end
   end

`ifdef UART_PARITY_EN
   logic rx_par_bad;

   // parity configuration, parity error flag and received-parity check
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_en  <= 1'b0;
         parity_odd <= 1'b0;
         parity_err <= 1'b0;
         rx_par_bad <= 1'b0;
      end else begin
         if (ctrl_hi_wr) begin
            parity_en  <= din[CTRL_PARITY_EN];
            parity_odd <= din[CTRL_PARITY_ODD];
         end
         parity_err <= (parity_err & ~(ctrl_hi_wr & din[CTRL_PARITY_ERR])) | (rx_push & rx_par_bad);
         if (rx_restart) rx_par_bad <= 1'b0;
         else if ((rx_state == RX_PARITY) && rx_sample)
            rx_par_bad <= rx_sync ^ parity_bit(rx_shift, parity_odd);
         else rx_par_bad <= rx_par_bad;
      end
   end
`else
   logic unused_parity_din;
   assign parity_en  = 1'b0;
   assign parity_odd = 1'b0;
   assign parity_err = 1'b0;
   assign unused_parity_din = ^{din[CTRL_PARITY_EN], din[CTRL_PARITY_ODD], din[CTRL_PARITY_ERR]};
`endif

   logic unused_din;
   assign unused_din = ^{din[24], din[15:8]};

   assign tx_tick    = (tx_div == 24'd0);
   assign tx_bit_end = tx_tick & (tx_os == 4'(OVERSAMPLE - 1));

   // TX next state, FIFO pop on frame start, next line level
   always_comb begin
      tx_next = tx_state;
      tx_pop  = 1'b0;
      tx_line = 1'b1;
      case (tx_state)
         TX_IDLE: begin
            if (!tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
            else tx_next = TX_IDLE;
         end
         TX_START: tx_next = tx_bit_end ? TX_DATA : TX_START;
         TX_DATA: begin
            if (tx_bit_end && (tx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
               tx_next = parity_en ? TX_PARITY : TX_STOP;
`else
               tx_next = TX_STOP;
`endif
            end else tx_next = TX_DATA;
         end
`ifdef UART_PARITY_EN
         TX_PARITY: tx_next = tx_bit_end ? TX_STOP : TX_PARITY;
`endif
         TX_STOP: begin
            if (tx_bit_end && !tx_empty) begin tx_next = TX_START; tx_pop = 1'b1; end
            else if (tx_bit_end) tx_next = TX_IDLE;
            else tx_next = TX_STOP;
         end
         default: tx_next = TX_IDLE;
      endcase
      if ((tx_state == TX_DATA) && tx_bit_end) tx_bit_nxt = tx_bit + 3'd1;
      else tx_bit_nxt = tx_bit;
      case (tx_next)
         TX_START:  tx_line = 1'b0;
         TX_DATA:   tx_line = tx_data[tx_bit_nxt];
`ifdef UART_PARITY_EN
         TX_PARITY: tx_line = parity_bit(tx_data, parity_odd);
`endif
         default:   tx_line = 1'b1;
      endcase
   end

   // TX state, line and bit timing; tick phase restarts on every frame start
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         uartTx   <= 1'b1;
         tx_div   <= 24'd0;
         tx_os    <= 4'd0;
         tx_bit   <= 3'd0;
         tx_data  <= 8'd0;
      end else begin
         tx_state <= tx_next;
         uartTx   <= tx_line;
         if (tx_pop) begin
            tx_data <= tx_head;
            tx_div  <= period_m1;
            tx_os   <= 4'd0;
            tx_bit  <= 3'd0;
         end else begin
            tx_bit <= tx_bit_nxt;
            if (tx_tick) begin tx_div <= period_m1; tx_os <= tx_os + 4'd1; end
            else tx_div <= tx_div - 24'd1;
         end
      end
   end

   assign rx_tick   = (rx_div == 24'd0);
   assign rx_sample = rx_tick & (rx_os == 4'(MID_SAMPLE - 1));

   // RX next state; the byte is pushed at the stop-bit sample
   always_comb begin
      rx_next    = rx_state;
      rx_push    = 1'b0;
      rx_restart = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            if (rx_prev && !rx_sync) begin rx_next = RX_START; rx_restart = 1'b1; end
            else rx_next = RX_IDLE;
         end
         RX_START: begin
            if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
            else rx_next = RX_START;
         end
         RX_DATA: begin
            if (rx_sample && (rx_bit == 3'd7)) begin
`ifdef UART_PARITY_EN
               rx_next = parity_en ? RX_PARITY : RX_STOP;
`else
               rx_next = RX_STOP;
`endif
            end else rx_next = RX_DATA;
         end
`ifdef UART_PARITY_EN
         RX_PARITY: rx_next = rx_sample ? RX_STOP : RX_PARITY;
`endif
         RX_STOP: begin
            if (rx_sample) begin rx_next = RX_IDLE; rx_push = 1'b1; end
            else rx_next = RX_STOP;
         end
         default: rx_next = RX_IDLE;
      endcase
      set_frame_err = rx_push & ~rx_sync;
      set_overrun   = rx_push & rx_full & ~data_rd;
   end

   // RX synchroniser, state, oversample timing and shift register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         rx_state <= RX_IDLE;
         rx_div   <= 24'd0;
         rx_os    <= 4'd0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'd0;
      end else begin
         rx_meta  <= uartRx;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         rx_state <= rx_next;
         if (rx_restart) begin
            rx_div <= period_m1;
            rx_os  <= 4'd0;
            rx_bit <= 3'd0;
         end else begin
            if (rx_tick) begin rx_div <= period_m1; rx_os <= rx_os + 4'd1; end
            else rx_div <= rx_div - 24'd1;
            if ((rx_state == RX_DATA) && rx_sample) begin
               rx_shift <= {rx_sync, rx_shift[7:1]};
               rx_bit   <= rx_bit + 3'd1;
            end
         end
      end
   end

   // registered interrupt request
   always_ff @(posedge clk or posedge rst) begin
      if (rst) interrupt <= 1'b0;
      else interrupt <= (rx_int_en & (~rx_empty | overrun | frame_err | parity_err)) |
                        (tx_int_en & tx_empty & (tx_state == TX_IDLE));
   end

endmodule

// File: tb/tb_uart_bus_port.sv
// Scoreboard bench for uart_bus_port (FIFO_DEPTH_BITS=2, PRESCALE=4, one bit = 64 cycles).
// Parity scenarios run only when UART_PARITY_EN is defined.
module tb_uart_bus_port;
   localparam int BIT = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] din;
   logic [3:0]  we;
   logic        en, sel;
   logic [7:0]  datRegOut;
   logic [31:0] ctrlRegOut;
   logic        interrupt, uartRx, uartTx;
   logic        loop_en, rx_drive;

   int checks = 0;
   int passed = 0;
   logic [7:0] rx_exp [$];
   logic       tx_exp [$];

   assign uartRx = loop_en ? uartTx : rx_drive;
   always #5 clk = ~clk;

   uart_bus_port #(.FIFO_DEPTH_BITS(2), .PRESCALE(4)) dut (
      .clk(clk), .rst(rst), .din(din), .we(we), .en(en), .sel(sel),
      .datRegOut(datRegOut), .ctrlRegOut(ctrlRegOut), .interrupt(interrupt),
      .uartRx(uartRx), .uartTx(uartTx)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic s, input logic [3:0] w, input logic [31:0] d);
      @(negedge clk);
      en = 1'b1; sel = s; we = w; din = d;
      @(negedge clk);
      en = 1'b0; sel = 1'b0; we = 4'b0000; din = 32'd0;
   endtask

   task automatic read_data(input string tag);
      logic [7:0] e;
      @(negedge clk);
      if (rx_exp.size() == 0) check_eq({tag, " sb empty"}, 32'(datRegOut), 32'hFFFF_FFFF);
      else begin
         e = rx_exp.pop_front();
         check_eq(tag, 32'(datRegOut), 32'(e));
      end
      en = 1'b1; sel = 1'b0; we = 4'b0000;
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic push_tx_frame(input logic [7:0] d, input logic with_par, input logic par);
      tx_exp.push_back(1'b0);
      for (int i = 0; i < 8; i++) tx_exp.push_back(d[i]);
      if (with_par) tx_exp.push_back(par);
      tx_exp.push_back(1'b1);
   endtask

   // called at the first cycle of the start bit; checks first and last cycle of every bit
   task automatic check_tx_frame(input string tag);
      logic b;
      int n;
      n = tx_exp.size();
      for (int i = 0; i < n; i++) begin
         b = tx_exp.pop_front();
         check_eq($sformatf("%s bit%0d first", tag, i), 32'(uartTx), 32'(b));
         tick(BIT - 1);
         check_eq($sformatf("%s bit%0d last", tag, i), 32'(uartTx), 32'(b));
         tick(1);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic with_par, input logic par, input logic stop);
      logic bits [$];
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (with_par) bits.push_back(par);
      bits.push_back(stop);
      foreach (bits[i]) begin
         rx_drive = bits[i];
         tick(BIT);
      end
      rx_drive = 1'b1;
   endtask

   task automatic wait_ctrl_bit(input int idx, input int budget, input string tag);
      int k;
      k = 0;
      while (!ctrlRegOut[idx] && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) check_eq(tag, 32'(ctrlRegOut[idx]), 32'd1);
   endtask

   task automatic wait_rx_level(input logic [7:0] lvl, input int budget, input string tag);
      int k;
      k = 0;
      while (ctrlRegOut[7:0] != lvl && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (k >= budget) check_eq(tag, 32'(ctrlRegOut[7:0]), 32'(lvl));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      rst = 1'b1; en = 1'b0; sel = 1'b0; we = 4'b0000; din = 32'd0;
      loop_en = 1'b0; rx_drive = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);

      check_eq("reset ctrl", ctrlRegOut, 32'h8001_0000);
      check_eq("reset uartTx", 32'(uartTx), 32'd1);
      check_eq("reset irq", 32'(interrupt), 32'd0);
      check_eq("reset dat", 32'(datRegOut), 32'd0);

      bus_write(1'b1, 4'b0100, 32'h0000_0000);
      check_eq("baud0 ctrl", ctrlRegOut, 32'h8000_0000);

      bus_write(1'b1, 4'b1000, 32'hF000_0000);
`ifdef UART_PARITY_EN
      check_eq("ctrl hi write", ctrlRegOut, 32'hF000_0000);
`else
      check_eq("ctrl hi write", ctrlRegOut, 32'hC000_0000);
`endif
      check_eq("tx irq latency", 32'(interrupt), 32'd0);
      tick(1);
      check_eq("tx irq set", 32'(interrupt), 32'd1);
      bus_write(1'b1, 4'b1000, 32'h8000_0000);
      check_eq("ctrl restore", ctrlRegOut, 32'h8000_0000);
      tick(2);

      // transmit 0xA5 with the receiver disconnected
      push_tx_frame(8'hA5, 1'b0, 1'b0);
      bus_write(1'b0, 4'b0001, 32'h0000_00A5);
      check_eq("tx pre-start line", 32'(uartTx), 32'd1);
      check_eq("tx level 1", 32'(ctrlRegOut[15:8]), 32'd1);
      tick(1);
      check_eq("tx level 0", 32'(ctrlRegOut[15:8]), 32'd0);
      check_tx_frame("txA5");

      // loopback 0x3C
      loop_en = 1'b1;
      tick(4);
      rx_exp.push_back(8'h3C);
      bus_write(1'b0, 4'b0001, 32'h0000_003C);
      wait_rx_level(8'd1, 1500, "rx 3C timeout");
      check_eq("rx level 1", 32'(ctrlRegOut[7:0]), 32'd1);
      check_eq("rx irq latency", 32'(interrupt), 32'd0);
      tick(1);
      check_eq("rx irq set", 32'(interrupt), 32'd1);
      read_data("rx 3C");
      check_eq("rx level after read", 32'(ctrlRegOut[7:0]), 32'd0);
      check_eq("irq before clear", 32'(interrupt), 32'd1);
      tick(1);
      check_eq("irq cleared", 32'(interrupt), 32'd0);
      check_eq("dat empty", 32'(datRegOut), 32'd0);
      tick(100);

      // five back-to-back frames into a four-entry RX FIFO
      for (int i = 0; i < 5; i++) begin
         d = 8'h11 * 8'(i + 1);
         if (i < 4) rx_exp.push_back(d);
         bus_write(1'b0, 4'b0001, 32'(d));
      end
      wait_ctrl_bit(27, 5000, "overrun timeout");
      check_eq("overrun set", 32'(ctrlRegOut[27]), 32'd1);
      check_eq("rx level full", 32'(ctrlRegOut[7:0]), 32'd4);
      tick(1);
      check_eq("overrun irq", 32'(interrupt), 32'd1);
      bus_write(1'b1, 4'b1000, 32'h8800_0000);
      check_eq("overrun cleared", ctrlRegOut, 32'h8000_0004);
      for (int i = 0; i < 4; i++) read_data($sformatf("rx burst%0d", i));
      check_eq("burst drained", ctrlRegOut, 32'h8000_0000);
      tick(100);

      // half-bit glitch is a false start
      loop_en = 1'b0;
      tick(10);
      rx_drive = 1'b0;
      tick(32);
      rx_drive = 1'b1;
      tick(200);
      check_eq("glitch ignored", ctrlRegOut, 32'h8000_0000);
      check_eq("glitch irq", 32'(interrupt), 32'd0);

      // low stop bit: byte kept, frame error flagged
      rx_exp.push_back(8'h5A);
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
      tick(20);
      check_eq("frame err set", 32'(ctrlRegOut[26]), 32'd1);
      check_eq("frame err level", 32'(ctrlRegOut[7:0]), 32'd1);
      read_data("rx bad stop");
      bus_write(1'b1, 4'b1000, 32'h8400_0000);
      check_eq("frame err cleared", ctrlRegOut, 32'h8000_0000);

`ifdef UART_PARITY_EN
      bus_write(1'b1, 4'b1000, 32'hB000_0000);
      loop_en = 1'b1;
      tick(4);
      push_tx_frame(8'h01, 1'b1, 1'b0);
      rx_exp.push_back(8'h01);
      bus_write(1'b0, 4'b0001, 32'h0000_0001);
      tick(1);
      check_tx_frame("par01");
      check_eq("parity ok", 32'(ctrlRegOut[25]), 32'd0);
      read_data("rx par01");
      loop_en = 1'b0;
      tick(10);
      rx_exp.push_back(8'h01);
      send_frame(8'h01, 1'b1, 1'b1, 1'b1);
      tick(20);
      check_eq("parity err set", 32'(ctrlRegOut[25]), 32'd1);
      read_data("rx bad parity");
`endif

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
